// File: rtl/boe_result_rx_if.sv
// Bus bundle for the BOE result-stream checker: frame control and result words in,
// registered frame summary out. Stats counters appear only when BOE_RX_STATS_EN is defined.
interface boe_result_rx_if #(
    parameter int DW = 8,
    parameter int RW = 11
);
    logic          start;
    logic [2:0]    frame_num;
    logic          res_valid;
    logic [RW-1:0] result;

    logic          busy;
    logic          frame_done;
    logic          frame_ok;
    logic [3:0]    err_code;
    logic [DW-1:0] max_q;
    logic [RW-1:0] sum_q;
    logic [DW-1:0] min_q;
`ifdef BOE_RX_STATS_EN
    logic [7:0]    ok_cnt;
    logic [7:0]    err_cnt;

    modport master (
        output start, frame_num, res_valid, result,
        input  busy, frame_done, frame_ok, err_code, max_q, sum_q, min_q, ok_cnt, err_cnt
    );
    modport slave (
        input  start, frame_num, res_valid, result,
        output busy, frame_done, frame_ok, err_code, max_q, sum_q, min_q, ok_cnt, err_cnt
    );
`else
    modport master (
        output start, frame_num, res_valid, result,
        input  busy, frame_done, frame_ok, err_code, max_q, sum_q, min_q
    );
    modport slave (
        input  start, frame_num, res_valid, result,
        output busy, frame_done, frame_ok, err_code, max_q, sum_q, min_q
    );
`endif
endinterface

// File: rtl/boe_result_rx.sv
// Receive-side checker for the BOE result stream: MAX, SUM, then N descending words per frame.
// Optional BOE_RX_STATS_EN adds saturating ok/err frame counters.
module boe_result_rx #(
    parameter int DW   = 8,
    parameter int RW   = 11,
    parameter int NMAX = 6
) (
    input  logic             clk,
    input  logic             rst,
    boe_result_rx_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        GET_MAX,
        GET_SUM,
        GET_SORT,
        DONE
    } state_t;

    localparam logic [2:0] NMAX_L = 3'(NMAX);

    state_t        state_q;
    logic [2:0]    n_q;
    logic [2:0]    idx_q;
    logic [RW-1:0] acc_q;
    logic [RW-1:0] prev_q;
    logic [RW-1:0] max_cap_q;
    logic [RW-1:0] sum_cap_q;
    logic [3:0]    err_q;

    logic          busy_q;
    logic          done_q;
    logic          ok_q;
    logic [3:0]    err_code_q;
    logic [DW-1:0] max_out_q;
    logic [RW-1:0] sum_out_q;
    logic [DW-1:0] min_out_q;

    logic          start_legal;
    logic          word_range_err;
    logic          last_word;
    logic [RW-1:0] acc_d;
    logic [3:0]    err_d;
    logic [3:0]    final_err_d;

    assign start_legal    = (bus.frame_num != 3'd0) && (bus.frame_num <= NMAX_L);
    assign word_range_err = |bus.result[RW-1:DW];
    assign last_word      = (idx_q == n_q - 3'd1);
    assign acc_d          = acc_q + bus.result;

    // Error bits contributed by the sorted word currently on the bus.
    always_comb begin
        err_d = err_q;
        if ((idx_q == 3'd0) && (bus.result != max_cap_q)) err_d[0] = 1'b1;
        if ((idx_q != 3'd0) && (bus.result > prev_q))     err_d[1] = 1'b1;
        if (word_range_err)                               err_d[3] = 1'b1;
        final_err_d    = err_d;
        final_err_d[2] = (acc_d != sum_cap_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            prev_q     <= '0;
            max_cap_q  <= '0;
            sum_cap_q  <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_code_q <= '0;
            max_out_q  <= '0;
            sum_out_q  <= '0;
            min_out_q  <= '0;
        end else begin
            // NOTE: the pulse is defaulted low every cycle and only the DONE entry raises it,
            // so frame_done can never stick high; sequential state uses <= throughout.
            done_q <= 1'b0;

            if (bus.start) begin
                // Start always wins: aborts a frame in flight and drops any same-cycle word.
                idx_q     <= '0;
                acc_q     <= '0;
                prev_q    <= '0;
                max_cap_q <= '0;
                sum_cap_q <= '0;
                busy_q    <= 1'b1;
                if (start_legal) begin
                    n_q     <= bus.frame_num;
                    err_q   <= '0;
                    state_q <= GET_MAX;
                end else begin
                    n_q        <= '0;
                    err_q      <= 4'b1000;
                    state_q    <= DONE;
                    done_q     <= 1'b1;
                    ok_q       <= 1'b0;
                    err_code_q <= 4'b1000;
                    max_out_q  <= '0;
                    sum_out_q  <= '0;
                    min_out_q  <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    GET_MAX: begin
                        if (bus.res_valid) begin
                            max_cap_q <= bus.result;
                            if (word_range_err) err_q[3] <= 1'b1;
                            state_q <= GET_SUM;
                        end
                    end
                    GET_SUM: begin
                        if (bus.res_valid) begin
                            sum_cap_q <= bus.result;
                            idx_q     <= '0;
                            state_q   <= GET_SORT;
                        end
                    end
                    GET_SORT: begin
                        if (bus.res_valid) begin
                            acc_q  <= acc_d;
                            prev_q <= bus.result;
                            err_q  <= err_d;
                            idx_q  <= idx_q + 3'd1;
                            if (last_word) begin
                                state_q    <= DONE;
                                done_q     <= 1'b1;
                                ok_q       <= (final_err_d == 4'b0000);
                                err_code_q <= final_err_d;
                                max_out_q  <= max_cap_q[DW-1:0];
                                sum_out_q  <= sum_cap_q;
                                min_out_q  <= bus.result[DW-1:0];
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.frame_ok   = ok_q;
    assign bus.err_code   = err_code_q;
    assign bus.max_q      = max_out_q;
    assign bus.sum_q      = sum_out_q;
    assign bus.min_q      = min_out_q;

`ifdef BOE_RX_STATS_EN
    logic [7:0] ok_cnt_q;
    logic [7:0] err_cnt_q;

    // Counts land at the end of the DONE cycle and saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (done_q) begin
            if (ok_q) begin
                if (ok_cnt_q != 8'hFF) ok_cnt_q <= ok_cnt_q + 8'd1;
            end else begin
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign bus.ok_cnt  = ok_cnt_q;
    assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_boe_result_rx.sv
// Directed, table-driven bench for boe_result_rx plus hand-written multi-cycle sequences.
module tb_boe_result_rx;
    localparam int DW = 8;
    localparam int RW = 11;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    boe_result_rx_if #(.DW(DW), .RW(RW)) bus ();

    boe_result_rx #(.DW(DW), .RW(RW), .NMAX(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          n;
        int          nw;
        logic [10:0] w [5];
        logic        ok;
        logic [3:0]  err;
        int          mx;
        int          sm;
        int          mn;
        bit          chk_data;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(int n, int nw, int w0, int w1, int w2, int w3, int w4,
                                logic ok, logic [3:0] err, int mx, int sm, int mn, bit chk);
        vec_t v;
        v.n = n; v.nw = nw;
        v.w[0] = 11'(w0); v.w[1] = 11'(w1); v.w[2] = 11'(w2); v.w[3] = 11'(w3); v.w[4] = 11'(w4);
        v.ok = ok; v.err = err; v.mx = mx; v.sm = sm; v.mn = mn; v.chk_data = chk;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_start(input int n);
        bus.start     = 1'b1;
        bus.frame_num = 3'(n);
        bus.res_valid = 1'b0;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic send_word(input int w);
        bus.res_valid = 1'b1;
        bus.result    = 11'(w);
        tick();
        bus.res_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        send_start(v.n);
        for (int k = 0; k < v.nw; k++) begin
            bus.res_valid = 1'b1;
            bus.result    = v.w[k];
            tick();
        end
        bus.res_valid = 1'b0;
        check({tag, ".done"}, 32'(bus.frame_done), 32'd1);
        check({tag, ".ok"},   32'(bus.frame_ok),   32'(v.ok));
        check({tag, ".err"},  32'(bus.err_code),   32'(v.err));
        if (v.chk_data) begin
            check({tag, ".max"}, 32'(bus.max_q), 32'(v.mx));
            check({tag, ".sum"}, 32'(bus.sum_q), 32'(v.sm));
            check({tag, ".min"}, 32'(bus.min_q), 32'(v.mn));
        end
        tick();
        check({tag, ".done_drop"}, 32'(bus.frame_done), 32'd0);
        check({tag, ".idle"},      32'(bus.busy),       32'd0);
        check({tag, ".ok_held"},   32'(bus.frame_ok),   32'(v.ok));
    endtask

    initial begin
        int ndone;
        bit busy_drop;
        bit early_done;
        int stall_w [8];

        bus.start     = 1'b0;
        bus.frame_num = '0;
        bus.res_valid = 1'b0;
        bus.result    = '0;
        rst           = 1'b1;

        vecs[0] = mk(3, 5,   9,  16,   9, 5, 2, 1'b1, 4'b0000,  9,  16,  2, 1'b1);
        vecs[1] = mk(3, 5,   9,  17,   9, 5, 2, 1'b0, 4'b0100,  9,  17,  2, 1'b1);
        vecs[2] = mk(3, 5,   9,  16,   5, 9, 2, 1'b0, 4'b0011,  9,  16,  2, 1'b1);
        vecs[3] = mk(0, 0,   0,   0,   0, 0, 0, 1'b0, 4'b1000,  0,   0,  0, 1'b0);
        vecs[4] = mk(1, 3, 300, 300, 300, 0, 0, 1'b0, 4'b1000, 44, 300, 44, 1'b1);
        vecs[5] = mk(7, 0,   0,   0,   0, 0, 0, 1'b0, 4'b1000,  0,   0,  0, 1'b0);

        #2;
        check("rst.busy", 32'(bus.busy),       32'd0);
        check("rst.done", 32'(bus.frame_done), 32'd0);
        check("rst.ok",   32'(bus.frame_ok),   32'd0);
        check("rst.err",  32'(bus.err_code),   32'd0);
        check("rst.max",  32'(bus.max_q),      32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
`ifdef BOE_RX_STATS_EN
            if (i == 3) begin
                check("stats.ok_cnt",  32'(bus.ok_cnt),  32'd1);
                check("stats.err_cnt", 32'(bus.err_cnt), 32'd3);
            end
`endif
        end

        // Stalls: two idle cycles between every word of an N=6 frame.
        stall_w = '{200, 1020, 200, 200, 200, 200, 110, 110};
        busy_drop  = 1'b0;
        early_done = 1'b0;
        send_start(6);
        for (int k = 0; k < 8; k++) begin
            send_word(stall_w[k]);
            if (k < 7) begin
                if (!bus.busy || bus.frame_done) early_done = early_done | bus.frame_done;
                if (!bus.busy) busy_drop = 1'b1;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    if (!bus.busy) busy_drop = 1'b1;
                    if (bus.frame_done) early_done = 1'b1;
                end
            end
        end
        check("stall.done",       32'(bus.frame_done), 32'd1);
        check("stall.busy_drop",  32'(busy_drop),      32'd0);
        check("stall.early_done", 32'(early_done),     32'd0);
        check("stall.ok",         32'(bus.frame_ok),   32'd1);
        check("stall.sum",        32'(bus.sum_q),      32'd1020);
        check("stall.min",        32'(bus.min_q),      32'd110);
        check("stall.max",        32'(bus.max_q),      32'd200);
        tick();

        // Abort: N=4 frame interrupted after three words, restarted as N=1.
        ndone = 0;
        send_start(4);
        for (int k = 0; k < 3; k++) begin
            send_word(k == 1 ? 16 : 9);
            if (bus.frame_done) ndone++;
        end
        send_start(1);
        if (bus.frame_done) ndone++;
        for (int k = 0; k < 3; k++) begin
            send_word(7);
            if (bus.frame_done) ndone++;
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            if (bus.frame_done) ndone++;
        end
        check("abort.ndone", 32'(ndone),        32'd1);
        check("abort.ok",    32'(bus.frame_ok), 32'd1);
        check("abort.max",   32'(bus.max_q),    32'd7);

        // Start with a same-cycle word: the word must be dropped.
        bus.start     = 1'b1;
        bus.frame_num = 3'd1;
        bus.res_valid = 1'b1;
        bus.result    = 11'd99;
        tick();
        bus.start     = 1'b0;
        bus.res_valid = 1'b0;
        send_word(5); send_word(5); send_word(5);
        check("collide.done", 32'(bus.frame_done), 32'd1);
        check("collide.err",  32'(bus.err_code),   32'd0);
        check("collide.max",  32'(bus.max_q),      32'd5);
        tick();

        // Start during DONE: old pulse stands, new frame begins next cycle.
        send_start(1);
        send_word(4); send_word(4); send_word(4);
        check("indone.done", 32'(bus.frame_done), 32'd1);
        check("indone.max",  32'(bus.max_q),      32'd4);
        send_start(1);
        check("indone.busy",      32'(bus.busy),       32'd1);
        check("indone.done_drop", 32'(bus.frame_done), 32'd0);
        check("indone.held_max",  32'(bus.max_q),      32'd4);
        send_word(3); send_word(3); send_word(3);
        check("indone.done2", 32'(bus.frame_done), 32'd1);
        check("indone.ok2",   32'(bus.frame_ok),   32'd1);
        check("indone.max2",  32'(bus.max_q),      32'd3);
        tick();

        // Asynchronous reset in GET_SORT.
        send_start(3);
        send_word(9); send_word(16); send_word(9);
        rst = 1'b1;
        #1;
        check("arst.busy", 32'(bus.busy),       32'd0);
        check("arst.done", 32'(bus.frame_done), 32'd0);
        check("arst.max",  32'(bus.max_q),      32'd0);
        check("arst.min",  32'(bus.min_q),      32'd0);
        check("arst.ok",   32'(bus.frame_ok),   32'd0);
`ifdef BOE_RX_STATS_EN
        check("arst.ok_cnt", 32'(bus.ok_cnt), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        run_vec(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
